// File: rtl/mdu_seq_pkg.sv
// Shared types for the iterative multiply/divide unit.
package mdu_seq_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mdu_state_t;

  // Divide family shares the top encoding bit.
  function automatic logic mdu_is_div(input mdu_op_t op);
    return op[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic mdu_a_signed(input mdu_op_t op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV)  || (op == MDU_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic mdu_b_signed(input mdu_op_t op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Request/response handshake bundle between the EXU and the mul/div unit.
interface mdu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  import mdu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  mdu_op_t          op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, Result
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, Result
  );

endinterface

// File: rtl/mdu_seq_step.sv
// One iteration of the mul/div datapath, purely combinational.
// acc layout: {hi[WIDTH:0], lo[WIDTH-1:0]}.
//   mul: hi = running partial product, lo = remaining multiplier bits.
//   div: hi = partial remainder, lo = dividend bits shifting out / quotient in.
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0]  acc,
  input  logic [WIDTH-1:0]  operand,
  input  logic              is_div,
  output logic [2*WIDTH:0]  acc_next
);

  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             take;

  // Add-shift for multiply, trial-subtract for restoring divide.
  always_comb begin
    hi       = acc[2*WIDTH:WIDTH];
    lo       = acc[WIDTH-1:0];
    addend   = lo[0] ? {1'b0, operand} : '0;
    sum      = hi + addend;
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = {1'b0, rem_sh} - {2'b00, operand};
    take     = ~diff[WIDTH+1];
    acc_next = '0;
    if (is_div) begin
      acc_next = {(take ? diff[WIDTH:0] : rem_sh), lo[WIDTH-2:0], take};
    end else begin
      acc_next = {1'b0, sum, lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit: one op in flight, one bit per cycle.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  mdu_seq_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0] LAST    = CNT_WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0]     INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_t       state_q, state_d;
  mdu_op_t          op_q;
  logic             sign_a_q, sign_b_q;
  logic [WIDTH-1:0] opnd_q;
  logic [2*WIDTH:0] acc_q;
  logic [2*WIDTH:0] acc_next;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             special;
  logic [WIDTH-1:0] special_val;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quot_s, rem_s;
  logic [WIDTH-1:0] fix_val;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Result    = result_q;

  assign accept = bus.in_valid && (state_q == IDLE) && !flush;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .is_div   (mdu_is_div(op_q)),
    .acc_next (acc_next)
  );

  // Operand signs/magnitudes and accept-time special cases.
  always_comb begin
    sign_a      = mdu_a_signed(bus.op) && bus.A[WIDTH-1];
    sign_b      = mdu_b_signed(bus.op) && bus.B[WIDTH-1];
    mag_a       = sign_a ? -bus.A : bus.A;
    mag_b       = sign_b ? -bus.B : bus.B;
    special     = 1'b0;
    special_val = '0;
    case (bus.op)
      MDU_DIV: begin
        if (bus.B == '0) begin
          special     = 1'b1;
          special_val = '1;
        end else if ((bus.A == INT_MIN) && (bus.B == '1)) begin
          special     = 1'b1;
          special_val = INT_MIN;
        end
      end
      MDU_DIVU: begin
        if (bus.B == '0) begin
          special     = 1'b1;
          special_val = '1;
        end
      end
      MDU_REM: begin
        if (bus.B == '0) begin
          special     = 1'b1;
          special_val = bus.A;
        end else if ((bus.A == INT_MIN) && (bus.B == '1)) begin
          special     = 1'b1;
          special_val = '0;
        end
      end
      MDU_REMU: begin
        if (bus.B == '0) begin
          special     = 1'b1;
          special_val = bus.A;
        end
      end
      default: ;
    endcase
  end

  // Sign correction and result selection after the last iteration.
  always_comb begin
    prod_s  = (sign_a_q ^ sign_b_q) ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quot_s  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s   = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fix_val = prod_s[WIDTH-1:0];
    case (op_q)
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_val = prod_s[2*WIDTH-1:WIDTH];
      MDU_DIV, MDU_DIVU:               fix_val = quot_s;
      MDU_REM, MDU_REMU:               fix_val = rem_s;
      default:                         fix_val = prod_s[WIDTH-1:0];
    endcase
  end

  // Next-state logic; flush wins over every other condition.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = special ? DONE : CALC;
        CALC: if (cnt_q == LAST) state_d = FIX;
        FIX:  state_d = DONE;
        DONE: if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers: latch at accept, iterate in CALC, finalise in FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= MDU_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // Multiplier and dividend both enter the low half; B magnitude
            // serves as multiplicand or divisor.
            op_q     <= bus.op;
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            opnd_q   <= mag_b;
            acc_q    <= {{(WIDTH+1){1'b0}}, mag_a};
            cnt_q    <= '0;
            if (special) result_q <= special_val;
          end
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
        FIX: result_q <= fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  mdu_seq_if #(.WIDTH(32)) bus ();

  mdu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one op; lat counts clock edges from the accept edge (inclusive)
  // until out_valid is seen. Optionally completes the output handshake.
  task automatic do_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input bit take, output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.op       = op;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.Result;
    if (take) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.Result !== 32'h0) begin
      errors++; $display("FAIL reset_result got %h want 00000000", bus.Result);
    end
  endtask

  task automatic test_mul();
    logic [31:0] r; int l;
    do_op(MDU_MUL, 32'd7, 32'hFFFFFFFD, 1'b1, r, l);
    checks++;
    if (r !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL mul_7_m3 got %h want ffffffeb", r);
    end
    checks++;
    if (l !== 34) begin
      errors++; $display("FAIL mul_latency got %0d want 34", l);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL mul_ready_after got %b want 1", bus.in_ready);
    end
    do_op(MDU_MUL, 32'h12345678, 32'h00000010, 1'b1, r, l);
    checks++;
    if (r !== 32'h23456780) begin
      errors++; $display("FAIL mul_shift got %h want 23456780", r);
    end
  endtask

  task automatic test_mul_high();
    logic [31:0] r; int l;
    do_op(MDU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, l);
    checks++;
    if (r !== 32'h00000000) begin
      errors++; $display("FAIL mulh_m1_m1 got %h want 00000000", r);
    end
    do_op(MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, l);
    checks++;
    if (r !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL mulhu_max got %h want fffffffe", r);
    end
    do_op(MDU_MULHSU, 32'hFFFFFFFF, 32'd2, 1'b1, r, l);
    checks++;
    if (r !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL mulhsu_m1_2 got %h want ffffffff", r);
    end
    do_op(MDU_MULHU, 32'h12345678, 32'h00000010, 1'b1, r, l);
    checks++;
    if (r !== 32'h00000001) begin
      errors++; $display("FAIL mulhu_shift got %h want 00000001", r);
    end
  endtask

  task automatic test_div();
    logic [31:0] r; int l;
    do_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, r, l);
    checks++;
    if (r !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_m7_2 got %h want fffffffd", r);
    end
    checks++;
    if (l !== 34) begin
      errors++; $display("FAIL div_latency got %0d want 34", l);
    end
    do_op(MDU_REM, 32'hFFFFFFF9, 32'd2, 1'b1, r, l);
    checks++;
    if (r !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL rem_m7_2 got %h want ffffffff", r);
    end
    do_op(MDU_DIVU, 32'd100, 32'd7, 1'b1, r, l);
    checks++;
    if (r !== 32'd14) begin
      errors++; $display("FAIL divu_100_7 got %h want 0000000e", r);
    end
    do_op(MDU_REMU, 32'd100, 32'd7, 1'b1, r, l);
    checks++;
    if (r !== 32'd2) begin
      errors++; $display("FAIL remu_100_7 got %h want 00000002", r);
    end
    do_op(MDU_DIV, 32'd7, 32'hFFFFFFFE, 1'b1, r, l);
    checks++;
    if (r !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_7_m2 got %h want fffffffd", r);
    end
    do_op(MDU_REM, 32'd7, 32'hFFFFFFFE, 1'b1, r, l);
    checks++;
    if (r !== 32'h00000001) begin
      errors++; $display("FAIL rem_7_m2 got %h want 00000001", r);
    end
  endtask

  task automatic test_special();
    logic [31:0] r; int l;
    do_op(MDU_DIVU, 32'd100, 32'd0, 1'b1, r, l);
    checks++;
    if (r !== 32'hFFFFFFFF || l !== 1) begin
      errors++; $display("FAIL divu_by0 got %h lat %0d want ffffffff lat 1", r, l);
    end
    do_op(MDU_REMU, 32'd100, 32'd0, 1'b1, r, l);
    checks++;
    if (r !== 32'd100 || l !== 1) begin
      errors++; $display("FAIL remu_by0 got %h lat %0d want 00000064 lat 1", r, l);
    end
    do_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, l);
    checks++;
    if (r !== 32'h80000000 || l !== 1) begin
      errors++; $display("FAIL div_ovf got %h lat %0d want 80000000 lat 1", r, l);
    end
    do_op(MDU_REM, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, l);
    checks++;
    if (r !== 32'h00000000 || l !== 1) begin
      errors++; $display("FAIL rem_ovf got %h lat %0d want 00000000 lat 1", r, l);
    end
    do_op(MDU_DIV, 32'hFFFFFFF9, 32'd0, 1'b1, r, l);
    checks++;
    if (r !== 32'hFFFFFFFF || l !== 1) begin
      errors++; $display("FAIL div_by0 got %h lat %0d want ffffffff lat 1", r, l);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; int l;
    do_op(MDU_DIVU, 32'd100, 32'd7, 1'b0, r, l);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.Result !== 32'd14 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v=%b r=%h rdy=%b want v=1 r=0000000e rdy=0",
                 i, bus.out_valid, bus.Result, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] r; int l; int seen;
    // Flush together with in_valid while idle: nothing may be accepted.
    @(negedge clk);
    bus.op = MDU_DIVU; bus.A = 32'd9; bus.B = 32'd0;
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_accept got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
    // Flush in the middle of CALC (counter 10).
    @(negedge clk);
    bus.op = MDU_MUL; bus.A = 32'd3; bus.B = 32'd5;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen);
    end
    do_op(MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, l);
    checks++;
    if (r !== 32'hFFFFFFFE || l !== 34) begin
      errors++; $display("FAIL flush_next_op got %h lat %0d want fffffffe lat 34", r, l);
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] r; int l;
    @(negedge clk);
    bus.op = MDU_DIVU; bus.A = 32'd1000; bus.B = 32'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.Result !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid got rdy=%b v=%b r=%h want rdy=1 v=0 r=00000000",
               bus.in_ready, bus.out_valid, bus.Result);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(MDU_DIVU, 32'd1000, 32'd3, 1'b1, r, l);
    checks++;
    if (r !== 32'd333 || l !== 34) begin
      errors++; $display("FAIL rst_next_op got %h lat %0d want 0000014d lat 34", r, l);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = MDU_MUL;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_mul();
    test_mul_high();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
